de_dispatch_ctrl: RTL

DE_DISPATCH_CTRL -- requirements
Module: de_dispatch_ctrl

---
 rtl/de_pkg.sv | 17 +
 rtl/de_bit_counter.sv | 34 +++
 rtl/de_dispatch_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/de_pkg.sv
// Shared definitions for the serial frame dispatch controller.
//   - deState_t           : FSM state encoding
//   - DEFAULT_PAYLOAD_LEN : default payload bits per frame
//   - CNT_W               : payload bit counter width
package de_pkg;

    localparam int unsigned DEFAULT_PAYLOAD_LEN = 8;
    localparam int unsigned CNT_W               = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        PAY  = 2'd2,
        DONE = 2'd3
    } deState_t;

endpackage

// File: rtl/de_bit_counter.sv
// Payload bit counter with synchronous clear, count enable and terminal flag.
//   iClk     : clock
//   iRst     : synchronous active-high reset
//   iClr     : clear count to zero (wins over iEn)
//   iEn      : increment count
//   oTerm_c  : combinational, high while count == TERMINAL
module de_bit_counter
    import de_pkg::*;
#(
    parameter int unsigned TERMINAL = DEFAULT_PAYLOAD_LEN - 1
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClr,
    input  logic iEn,
    output logic oTerm_c
);

    logic [CNT_W-1:0] count;

    // Count register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            count <= '0;
        end else if (iClr) begin
            count <= '0;
        end else if (iEn) begin
            count <= count + CNT_W'(1);
        end
    end

    assign oTerm_c = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/de_dispatch_ctrl.sv
// Serial frame dispatcher: receives a 2-bit address followed by PAYLOAD_LEN
// payload bits and drives a 1-to-4 demux (oS0/oS1 select, oC data).
//   iClk, iRst      : clock, synchronous active-high reset
//   iValid, iStart  : bit qualifier and frame marker
//   iData           : serial frame bit (addr0, addr1, payload...)
//   oS0, oS1, oC    : demux select/data, wired straight to the demux
//   oCEn            : oC carries a payload bit this cycle
//   oBusy           : frame in progress (ADDR, PAY, DONE)
//   oDone, oErr     : one-cycle completion / abort pulses
//   oFrames         : completed frame count, modulo 256
module de_dispatch_ctrl
    import de_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = DEFAULT_PAYLOAD_LEN
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic             iStart,
    input  logic             iData,
    output logic             oS0,
    output logic             oS1,
    output logic             oC,
    output logic             oCEn,
    output logic             oBusy,
    output logic             oDone,
    output logic             oErr,
    output logic [CNT_W-1:0] oFrames
);

    deState_t state;
    logic     s0;
    logic     cntClr;
    logic     cntEn;
    logic     cntTerm;

    // Counter restarts on the ADDR->PAY edge and advances per accepted payload bit
    assign cntClr = (state == ADDR) && iValid && !iStart;
    assign cntEn  = (state == PAY)  && iValid && !iStart;

    de_bit_counter #(
        .TERMINAL (PAYLOAD_LEN - 1)
    ) uBitCounter (
        .iClk    (iClk),
        .iRst    (iRst),
        .iClr    (cntClr),
        .iEn     (cntEn),
        .oTerm_c (cntTerm)
    );

    // Frame FSM with registered outputs. Address bit1 is captured straight
    // into oS1 on the same edge that oS0 takes the bit0 shadow, so the demux
    // select only ever changes as a complete pair.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            s0      <= 1'b0;
            oS0     <= 1'b0;
            oS1     <= 1'b0;
            oC      <= 1'b0;
            oCEn    <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oErr    <= 1'b0;
            oFrames <= '0;
        end else begin
            oCEn  <= 1'b0;
            oDone <= 1'b0;
            oErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (iValid && iStart) begin
                        s0    <= iData;
                        oBusy <= 1'b1;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (iValid) begin
                        if (iStart) begin
                            // restart: new address bit0, stay in ADDR
                            oErr <= 1'b1;
                            s0   <= iData;
                        end else begin
                            oS0   <= s0;
                            oS1   <= iData;
                            state <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (iValid) begin
                        if (iStart) begin
                            oErr  <= 1'b1;
                            s0    <= iData;
                            state <= ADDR;
                        end else begin
                            oC   <= iData;
                            oCEn <= 1'b1;
                            if (cntTerm) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    // inputs are ignored here
                    oDone   <= 1'b1;
                    oFrames <= oFrames + CNT_W'(1);
                    oC      <= 1'b0;
                    oBusy   <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
